// File: rtl/dm_host_ctrl_if.sv
// Host-controller bus bundle: load stream, data-memory port, dump stream and core start/halt.
// "master" is the controller side, "slave" is the environment (memory, core, stream endpoints).
interface dm_host_ctrl_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          go;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [15:0]   cycle_ct;
    logic          ld_valid;
    logic          ld_ready;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en;
    logic          mem_rd_en;
    logic [DW-1:0] mem_wr_data;
    logic [DW-1:0] mem_rd_data;
    logic [AW-1:0] dump_base;
    logic [AW-1:0] dump_len;
    logic          dp_valid;
    logic          dp_ready;
    logic [DW-1:0] dp_data;
    logic          dp_last;
    logic          start;
    logic          halt;

    modport master (
        input  go, ld_valid, ld_data, ld_last, mem_rd_data,
               dump_base, dump_len, dp_ready, halt,
        output busy, done, timeout, cycle_ct, ld_ready,
               mem_addr, mem_wr_en, mem_rd_en, mem_wr_data,
               dp_valid, dp_data, dp_last, start
    );

    modport slave (
        output go, ld_valid, ld_data, ld_last, mem_rd_data,
               dump_base, dump_len, dp_ready, halt,
        input  busy, done, timeout, cycle_ct, ld_ready,
               mem_addr, mem_wr_en, mem_rd_en, mem_wr_data,
               dp_valid, dp_data, dp_last, start
    );
endinterface

// File: rtl/dm_host_ctrl.sv
// Host sequencer: streams an image into data memory, pulses start, times the run until
// halt (or timeout), then streams a window of data memory back out.
module dm_host_ctrl #(
    parameter int          AW           = 8,
    parameter int          DW           = 8,
    parameter int          START_CYCLES = 2,
    parameter logic [15:0] TIMEOUT      = 16'hFFFF
) (
    input  logic             CLK,
    input  logic             reset,
    dm_host_ctrl_if.master   bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_RUN, S_DUMP_RD, S_DUMP_OUT, S_DONE
    } state_t;

    localparam logic [AW:0] ONE     = (AW+1)'(1);
    localparam logic [3:0]  SC_LAST = 4'(START_CYCLES - 1);

    state_t        state_q, state_d;
    // One extra bit so that a full 2**AW-beat load is visible as a carry.
    logic [AW:0]   ptr_q, ptr_d, ptr_inc;
    logic [AW-1:0] base_q, base_d, len_q, len_d;
    logic [3:0]    stc_q, stc_d;
    logic [15:0]   cyc_q, cyc_d;
    logic          to_q, to_d;
    logic [DW-1:0] dpd_q, dpd_d;
    logic          dump_last;

    assign ptr_inc   = ptr_q + ONE;
    assign dump_last = (ptr_q == ({1'b0, len_q} - ONE));

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            base_q  <= '0;
            len_q   <= '0;
            stc_q   <= '0;
            cyc_q   <= '0;
            to_q    <= 1'b0;
            dpd_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            base_q  <= base_d;
            len_q   <= len_d;
            stc_q   <= stc_d;
            cyc_q   <= cyc_d;
            to_q    <= to_d;
            dpd_q   <= dpd_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        base_d          = base_q;
        len_d           = len_q;
        stc_d           = stc_q;
        cyc_d           = cyc_q;
        to_d            = to_q;
        dpd_d           = dpd_q;
        bus.ld_ready    = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_rd_en   = 1'b0;
        bus.mem_wr_data = '0;
        bus.dp_valid    = 1'b0;
        bus.dp_last     = 1'b0;
        bus.start       = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.go) begin
                    state_d = S_LOAD;
                    base_d  = bus.dump_base;
                    len_d   = bus.dump_len;
                    to_d    = 1'b0;
                    cyc_d   = '0;
                    ptr_d   = '0;
                end
            end
            S_LOAD: begin
                bus.ld_ready = 1'b1;
                if (bus.ld_valid) begin
                    bus.mem_wr_en   = 1'b1;
                    bus.mem_addr    = ptr_q[AW-1:0];
                    bus.mem_wr_data = bus.ld_data;
                    ptr_d           = ptr_inc;
                    if (bus.ld_last || ptr_inc[AW]) begin
                        state_d = S_START;
                        stc_d   = '0;
                    end
                end
            end
            S_START: begin
                bus.start = 1'b1;
                ptr_d     = '0;
                if (stc_q == SC_LAST) state_d = S_RUN;
                else                  stc_d   = stc_q + 4'd1;
            end
            S_RUN: begin
                // Halt takes priority over a coincident timeout.
                if (bus.halt) begin
                    state_d = (len_q == '0) ? S_DONE : S_DUMP_RD;
                end else if (cyc_q == TIMEOUT) begin
                    to_d    = 1'b1;
                    state_d = (len_q == '0) ? S_DONE : S_DUMP_RD;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            S_DUMP_RD: begin
                bus.mem_rd_en = 1'b1;
                bus.mem_addr  = base_q + ptr_q[AW-1:0];
                dpd_d         = bus.mem_rd_data;
                state_d       = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                bus.dp_valid = 1'b1;
                bus.dp_last  = dump_last;
                if (bus.dp_ready) begin
                    ptr_d   = ptr_inc;
                    state_d = dump_last ? S_DONE : S_DUMP_RD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.timeout  = to_q;
    assign bus.cycle_ct = cyc_q;
    assign bus.dp_data  = dpd_q;
endmodule

// File: doc/dm_host_ctrl.md
Name: dm_host_ctrl

Overview:
Host-side controller for the single-cycle processor and its data memory. It streams a byte image into data memory, pulses the processor's start, and counts cycles until halt. It then reads a window of data memory back out as a byte stream. It is the memory/control initiator's counterpart: it supplies start and consumes halt, and it writes then reads data memory through the same port the core uses.

Parameters:
AW, 8, data memory address width (depth 2**AW)
DW, 8, data width
START_CYCLES, 2, cycles the start output is held high (range 1..15)
TIMEOUT, 16'hFFFF, run-cycle limit before forced stop

Ports:
CLK  in  1  clock, posedge
reset  in  1  asynchronous, active-low reset
go  in  1  one-cycle request to begin a load/run/dump sequence
busy  out  1  high from accepted go until done
done  out  1  sequence complete, held until next accepted go
timeout  out  1  run ended by TIMEOUT, not halt; valid while done
cycle_ct  out  16  processor cycles from start deassert to halt
ld_valid  in  1  load byte valid
ld_ready  out  1  controller accepts load byte
ld_data  in  DW  load byte
ld_last  in  1  final load byte
mem_addr  out  AW  data memory address
mem_wr_en  out  1  data memory write enable
mem_rd_en  out  1  data memory read enable
mem_wr_data  out  DW  data memory write data
mem_rd_data  in  DW  data memory read data, combinational from mem_addr
dump_base  in  AW  first address to dump, sampled on accepted go
dump_len  in  AW  bytes to dump, sampled on go; 0 = skip dump
dp_valid  out  1  dump byte valid
dp_ready  in  1  sink accepts dump byte
dp_data  out  DW  dump byte
dp_last  out  1  final dump byte
start  out  1  processor init, active high
halt  in  1  processor done flag

Behaviour:
- Reset (reset low, asynchronous): state IDLE. All outputs are 0, including start, and cycle_ct=0. Reset mid-sequence aborts immediately; no partial-state recovery.
- FSM states: IDLE, LOAD, START, RUN, DUMP_RD, DUMP_OUT, DONE.
- IDLE/DONE: go=1 -> LOAD. On that edge: latch dump_base and dump_len, clear done, timeout and cycle_ct, set load pointer to 0, set busy. go is ignored while busy.
- LOAD: ld_ready=1.
  - Each ld_valid&&ld_ready cycle drives mem_wr_en=1, mem_addr=pointer, mem_wr_data=ld_data, in the same cycle; pointer then increments.
  - Exit to START after the beat carrying ld_last, or after the beat written at address 2**AW-1, whichever comes first. Excess bytes are not accepted.
  - ld_valid=0 just stalls.
- START: start=1 for exactly START_CYCLES cycles, then RUN. halt is ignored in START.
- RUN: start=0, and cycle_ct increments each cycle halt=0.
  - halt=1 -> DUMP_RD, or DONE if dump_len=0; cycle_ct holds.
  - cycle_ct==TIMEOUT with halt=0 -> set timeout and leave as for halt.
  - Halt and timeout on the same cycle: halt wins, timeout=0.
- DUMP_RD: mem_rd_en=1, mem_addr=dump_base+index (mod 2**AW, wraps). mem_rd_data is registered into dp_data at the edge, then DUMP_OUT.
- DUMP_OUT: dp_valid=1; dp_data is stable until accepted; dp_last=1 when index==dump_len-1.
  - On dp_ready: index++; -> DUMP_RD, or DONE after the last byte.
  - Throughput is one byte per 2 cycles.
  - dp_valid never drops without dp_ready.
- DONE: done=1, busy=0; cycle_ct and timeout hold. mem_* outputs are 0 outside LOAD and DUMP_RD so the core owns the memory during RUN.
- Widths: the pointer/index counter is AW+1 bits so that 2**AW load beats are detected. cycle_ct saturates at TIMEOUT.

Test Plan:
- Load 4 bytes 11,22,33,44 (last on 4th), halt 10 cycles after start falls, dump_base=0, dump_len=4 -> writes to addr 0..3; start high 2 cycles; cycle_ct=10; dump 11,22,33,44 with dp_last on 44; done=1, timeout=0.
- dp_ready toggled 1/0 every cycle during dump -> no byte lost or duplicated; dp_data stable while dp_valid&&!dp_ready.
- dump_base=8'hFE, dump_len=3 -> reads addresses FE, FF, 00 in order.
- halt never asserted, TIMEOUT=20 -> cycle_ct=20, timeout=1, dump still performed, done=1.
- Load 300 beats without ld_last -> exactly 256 accepted (addr 0..FF), ld_ready drops, start follows; halt high during START ignored.
- reset low mid-RUN with start=0 and cycle_ct=7 -> all outputs 0 asynchronously; after release, go restarts cleanly from LOAD.
